// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: SD-card CMD-line controller.
//
// Accepts one command at a time, serialises the 48-bit command frame
// {start 0, transmit 1, index, argument, CRC7, end 1} onto the CMD line,
// optionally waits for and receives a 48-bit short response, and then keeps
// the line released for NCC bit times before it accepts the next command.
// All bit-level activity advances only on cycles where tick=1.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tick            one-cycle SD bit-clock strobe
//   cmd_valid/ready command handshake (ready only while idle)
//   cmd_index/arg   command index and argument
//   rsp_type        00 none, 01/11 short with CRC+index check, 10 short unchecked
//   sd_cmd_o/oe     CMD line drive value and output enable
//   sd_cmd_i        sampled CMD line
//   rsp_valid       one-cycle transaction-done pulse
//   rsp_index/arg   fields of the last received response
//   err_*           timeout, CRC, end-bit and index error flags
module sd_cmd_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int NCC     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  rsp_type,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  input  logic        sd_cmd_i,
  output logic        rsp_valid,
  output logic [5:0]  rsp_index,
  output logic [31:0] rsp_arg,
  output logic        err_timeout,
  output logic        err_crc,
  output logic        err_end,
  output logic        err_index
);

  // One shared counter serves the bit, timeout and gap phases, so it must
  // hold the largest of the three limits.
  localparam int MAX_TN = (TIMEOUT > NCC) ? TIMEOUT : NCC;
  localparam int MAXC   = (MAX_TN > 48) ? MAX_TN : 48;
  localparam int CNT_W  = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(47);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NCC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    RECV,
    GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [46:0]      tx_sr;   // frame bits still to be sent, next bit at [46]
  logic [46:0]      rx_sr;   // response bits received so far, newest at [0]
  logic [1:0]       rtype;
  logic [5:0]       idx_q;

  // CRC7, polynomial x^7 + x^3 + 1, zero initial value, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  logic [39:0] tx_body;
  logic [47:0] tx_frame;
  logic [47:0] rx_full;
  logic [6:0]  rx_crc;
  logic        rx_checked;

  assign tx_body    = {2'b01, cmd_index, cmd_arg};
  assign tx_frame   = {tx_body, crc7(tx_body), 1'b1};
  // The final response bit is taken straight from the line on the last tick.
  assign rx_full    = {rx_sr, sd_cmd_i};
  assign rx_crc     = crc7(rx_full[47:8]);
  assign rx_checked = (rtype != 2'b10);

  // Control: state machine, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      sd_cmd_oe   <= 1'b0;
      sd_cmd_o    <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_index   <= '0;
      rsp_arg     <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      err_end     <= 1'b0;
      err_index   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Acceptance does not wait for a tick; the first bit is driven
          // immediately and held until the first tick.
          if (cmd_valid) begin
            state       <= SEND;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            sd_cmd_oe   <= 1'b1;
            sd_cmd_o    <= tx_frame[47];
            err_timeout <= 1'b0;
            err_crc     <= 1'b0;
            err_end     <= 1'b0;
            err_index   <= 1'b0;
          end
        end
        SEND: begin
          if (tick) begin
            if (cnt == LAST_BIT) begin
              sd_cmd_oe <= 1'b0;
              sd_cmd_o  <= 1'b1;
              cnt       <= '0;
              if (rtype == 2'b00) begin
                state     <= GAP;
                rsp_valid <= 1'b1;
              end else begin
                state <= WAIT_RSP;
              end
            end else begin
              sd_cmd_o <= tx_sr[46];
              cnt      <= cnt + CNT_ONE;
            end
          end
        end
        WAIT_RSP: begin
          if (tick) begin
            if (!sd_cmd_i) begin
              // Start bit counts as the first received bit.
              state <= RECV;
              cnt   <= CNT_ONE;
            end else if (cnt == TO_LAST) begin
              state       <= GAP;
              cnt         <= '0;
              err_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        RECV: begin
          if (tick) begin
            if (cnt == LAST_BIT) begin
              state     <= GAP;
              cnt       <= '0;
              rsp_valid <= 1'b1;
              rsp_index <= rx_full[45:40];
              rsp_arg   <= rx_full[39:8];
              err_end   <= ~rx_full[0];
              if (rx_checked) begin
                err_crc   <= (rx_full[7:1] != rx_crc);
                err_index <= (rx_full[45:40] != idx_q);
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt == GAP_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              cmd_ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          cmd_ready <= 1'b1;
          sd_cmd_oe <= 1'b0;
          sd_cmd_o  <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: frame and response shift registers, latched command context
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      tx_sr <= tx_frame[46:0];
      rtype <= rsp_type;
      idx_q <= cmd_index;
    end else if (state == SEND && tick) begin
      tx_sr <= {tx_sr[45:0], 1'b0};
    end

    // Cleared while waiting so the start bit (0) already sits at [0] when
    // reception begins.
    if (state == WAIT_RSP) begin
      rx_sr <= '0;
    end else if (state == RECV && tick) begin
      rx_sr <= {rx_sr[45:0], sd_cmd_i};
    end
  end

endmodule
